// File: rtl/pixel_writer_pkg.sv
// Shared FSM encodings, default parameters and helpers for the pixel stream writer.
// Optional byte-gap resync is enabled with the PSW_BYTE_TIMEOUT_EN macro.
package pixel_writer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_WRITE   = 2'd2;

  localparam int unsigned DEF_BYTES_PER_PIXEL = 3;
  localparam int unsigned DEF_ADDR_W          = 18;
  localparam int unsigned DEF_FRAME_PIXELS    = 196608;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 100000;

  // Width of the per-pixel byte counter.
  function automatic int unsigned byte_cnt_w(input int unsigned bpp);
    return $clog2(bpp) + 1;
  endfunction

endpackage

// File: rtl/pixel_stream_writer_assembler.sv
// Byte shift register and byte counter; flags the byte that completes a pixel.
// The byte count port exists only when PSW_BYTE_TIMEOUT_EN is defined.
module pixel_assembler
  import pixel_writer_pkg::*;
#(
  parameter  int unsigned BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
  localparam int unsigned PIX_W           = 8 * BYTES_PER_PIXEL,
  localparam int unsigned CNT_W           = byte_cnt_w(BYTES_PER_PIXEL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [7:0]       i_byte,
`ifdef PSW_BYTE_TIMEOUT_EN
  output logic [CNT_W-1:0] o_byte_cnt,
`endif
  output logic [PIX_W-1:0] o_pixel_c,
  output logic             o_pixel_valid_c
);

  logic [PIX_W-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last          = (r_cnt == CNT_W'(BYTES_PER_PIXEL - 1));
  // Oldest byte ends up in the MSBs once BYTES_PER_PIXEL bytes have been shifted in.
  assign o_pixel_c       = PIX_W'({r_shift, i_byte});
  assign o_pixel_valid_c = i_valid & ~i_clear & w_last;
`ifdef PSW_BYTE_TIMEOUT_EN
  assign o_byte_cnt      = r_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shift <= o_pixel_c;
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pixel_stream_writer.sv
// Packs a UART byte stream into pixel words and writes them sequentially to frame BRAM.
// Define PSW_BYTE_TIMEOUT_EN to discard partial pixels after TIMEOUT_CYCLES of silence.
module pixel_stream_writer
  import pixel_writer_pkg::*;
#(
  parameter  int unsigned BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
  parameter  int unsigned ADDR_W          = DEF_ADDR_W,
  parameter  int unsigned FRAME_PIXELS    = DEF_FRAME_PIXELS,
  parameter  int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  localparam int unsigned PIX_W           = 8 * BYTES_PER_PIXEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_received,
  input  logic              rx_data_ready,
  input  logic              abort,
  output logic              en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  din,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_err,
  output logic [1:0]        status
);

  localparam int unsigned       CNT_W     = byte_cnt_w(BYTES_PER_PIXEL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  if (BYTES_PER_PIXEL < 1 || BYTES_PER_PIXEL > 4 || FRAME_PIXELS == 0 ||
      64'(FRAME_PIXELS) > (64'd1 << ADDR_W) || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("pixel_stream_writer: parameter out of range");
  end

  logic              r_rx;
  logic [7:0]        r_byte;
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_addr_inc;
  logic [PIX_W-1:0]  r_din, w_din_nxt, w_pixel;
  logic              r_we, w_we_nxt;
  logic              r_frame_done, w_frame_done_nxt;
  logic              r_sync_err, r_busy;
  logic              w_pixel_valid, w_timeout, w_clear;

  // Input capture stage: all control decisions use the registered strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx   <= 1'b0;
      r_byte <= '0;
    end else begin
      r_rx   <= rx_data_ready;
      r_byte <= byte_received;
    end
  end

`ifdef PSW_BYTE_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [GAP_W-1:0] r_gap;
  logic [CNT_W-1:0] w_byte_cnt;
  logic             w_counting;

  // Gap timer runs only while a partial pixel is waiting for more bytes.
  assign w_counting = (r_state == ST_COLLECT) && (w_byte_cnt != '0) && !r_rx;
  assign w_timeout  = w_counting && (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gap <= '0;
    end else if (!w_counting || w_timeout) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + GAP_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_clear = abort | w_timeout;

  pixel_assembler #(
    .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
  ) u_assembler (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_clear),
    .i_valid         (r_rx),
    .i_byte          (r_byte),
`ifdef PSW_BYTE_TIMEOUT_EN
    .o_byte_cnt      (w_byte_cnt),
`endif
    .o_pixel_c       (w_pixel),
    .o_pixel_valid_c (w_pixel_valid)
  );

  assign w_addr_inc = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);

  // Next-state logic; a completed pixel always lands in WRITE so no byte is lost.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_din_nxt        = r_din;
    w_we_nxt         = 1'b0;
    w_frame_done_nxt = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_addr_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (w_pixel_valid) begin
            w_state_nxt      = ST_WRITE;
            w_din_nxt        = w_pixel;
            w_we_nxt         = 1'b1;
            w_frame_done_nxt = (r_addr == LAST_ADDR);
          end else if (r_rx) begin
            w_state_nxt = ST_COLLECT;
          end
        end
        ST_WRITE: begin
          w_addr_nxt = w_addr_inc;
          if (w_pixel_valid) begin
            w_state_nxt      = ST_WRITE;
            w_din_nxt        = w_pixel;
            w_we_nxt         = 1'b1;
            w_frame_done_nxt = (w_addr_inc == LAST_ADDR);
          end else if (r_rx || r_addr != LAST_ADDR) begin
            w_state_nxt = ST_COLLECT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_din        <= '0;
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_din        <= w_din_nxt;
      r_we         <= w_we_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_sync_err   <= w_timeout;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign en         = r_we;
  assign we         = r_we;
  assign addr       = r_addr;
  assign din        = r_din;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign status     = r_state;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Self-checking bench for pixel_stream_writer (3 bytes/pixel, 4-pixel frame).
// Sections guarded by PSW_BYTE_TIMEOUT_EN exercise the byte-gap resync.
module tb_pixel_stream_writer;

  localparam int unsigned BPP = 3;
  localparam int unsigned AW  = 4;
  localparam int unsigned FP  = 4;
  localparam int unsigned TO  = 16;

  logic          clk, rst, rx_data_ready, abort;
  logic [7:0]    byte_received;
  logic          en, we, busy, frame_done, sync_err;
  logic [AW-1:0] addr;
  logic [23:0]   din;
  logic [1:0]    status;

  int  n_chk, n_err;
  bit  chk_en;

  pixel_stream_writer #(
    .BYTES_PER_PIXEL (BPP),
    .ADDR_W          (AW),
    .FRAME_PIXELS    (FP),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_received (byte_received),
    .rx_data_ready (rx_data_ready),
    .abort         (abort),
    .en            (en),
    .we            (we),
    .addr          (addr),
    .din           (din),
    .busy          (busy),
    .frame_done    (frame_done),
    .sync_err      (sync_err),
    .status        (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] b, input logic a);
    @(posedge clk);
    #1;
    rx_data_ready = r;
    byte_received = b;
    abort         = a;
    @(negedge clk);
  endtask

  // Reference model: bytes accepted one cycle after their strobe, packed MSB-first,
  // each completed pixel written on the following cycle at a modulo-FP address.
  logic        m_rx, m_we, m_busy;
  logic [7:0]  m_b;
  logic [23:0] m_acc, m_din;
  int          m_cnt, m_addr, m_wa;

  always @(posedge clk) begin : model
    int          cnt, a, wa;
    logic [23:0] acc, d;
    logic        w, bz;
    cnt = m_cnt; acc = m_acc; a = m_addr; d = m_din; bz = m_busy; wa = m_wa; w = 1'b0;
    if (!rst) begin
      cnt = 0; acc = '0; a = 0; d = '0; bz = 1'b0; wa = 0;
    end else if (abort) begin
      cnt = 0; a = 0; bz = 1'b0;
    end else if (m_rx) begin
      acc = {acc[15:0], m_b};
      cnt++;
      bz  = 1'b1;
      if (cnt == BPP) begin
        w = 1'b1; wa = a; d = acc; a = (a + 1) % FP; cnt = 0;
      end
    end else if (m_we && m_wa == FP - 1) begin
      bz = 1'b0;
    end
    m_rx   <= rst ? rx_data_ready : 1'b0;
    m_b    <= rst ? byte_received : 8'h00;
    m_cnt  <= cnt;
    m_acc  <= acc;
    m_addr <= a;
    m_din  <= d;
    m_busy <= bz;
    m_wa   <= wa;
    m_we   <= w;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_we",         32'(we),         32'(m_we));
      chk("mdl_en",         32'(en),         32'(m_we));
      chk("mdl_addr",       32'(addr),       m_we ? 32'(m_wa) : 32'(m_addr));
      chk("mdl_din",        32'(din),        32'(m_din));
      chk("mdl_frame_done", 32'(frame_done), 32'(m_we && (m_wa == FP - 1)));
      chk("mdl_busy",       32'(busy),       32'(m_busy));
      chk("mdl_status",     32'(status),     m_we ? 32'd2 : (m_busy ? 32'd1 : 32'd0));
      chk("mdl_sync_err",   32'(sync_err),   32'd0);
    end
  end

  typedef struct {
    logic        rdy;
    logic [7:0]  b;
    logic        ab;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [23:0] e_din;
    logic        e_busy;
  } vec_t;

  vec_t        vt [21];
  logic [7:0]  seq [16];
  logic [23:0] px  [4];
  int          k, n_se, n_wr;
  logic [23:0] last_din;
  logic [3:0]  last_addr;

  initial begin
    n_chk = 0; n_err = 0; chk_en = 1'b0;
    rst = 1'b0; rx_data_ready = 1'b0; abort = 1'b0; byte_received = '0;

    // single pixel, latency, then abort mid-pixel and abort racing a completing byte
    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b0};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b1};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h000000, 1'b1};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 24'h112233, 1'b1};
    vt[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 4'd1, 24'h112233, 1'b1};
    vt[6]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 4'd1, 24'h112233, 1'b1};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 24'h112233, 1'b1};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd1, 24'h112233, 1'b1};
    vt[9]  = '{1'b1, 8'h01, 1'b0, 1'b0, 4'd0, 24'h112233, 1'b0};
    vt[10] = '{1'b1, 8'h02, 1'b0, 1'b0, 4'd0, 24'h112233, 1'b0};
    vt[11] = '{1'b1, 8'h03, 1'b0, 1'b0, 4'd0, 24'h112233, 1'b1};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h112233, 1'b1};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 24'h010203, 1'b1};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 24'h010203, 1'b1};
    vt[15] = '{1'b1, 8'h04, 1'b0, 1'b0, 4'd1, 24'h010203, 1'b1};
    vt[16] = '{1'b1, 8'h05, 1'b0, 1'b0, 4'd1, 24'h010203, 1'b1};
    vt[17] = '{1'b1, 8'h06, 1'b0, 1'b0, 4'd1, 24'h010203, 1'b1};
    vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd1, 24'h010203, 1'b1};
    vt[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h010203, 1'b0};
    vt[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 24'h010203, 1'b0};

    seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h12, 8'h34,
            8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00};
    px  = '{24'hAABBCC, 24'hDDEEFF, 24'h123456, 24'h789ABC};

    // reset held while bytes stream in
    for (int i = 0; i < 6; i++) begin
      drive(i < 5, 8'($urandom), 1'b0);
      chk_en = 1'b1;
      chk("rst_en",   32'(en),   32'd0);
      chk("rst_we",   32'(we),   32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_din",  32'(din),  32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vt[i].rdy, vt[i].b, vt[i].ab);
      chk($sformatf("vec%0d_we", i),   32'(we),   32'(vt[i].e_we));
      chk($sformatf("vec%0d_addr", i), 32'(addr), 32'(vt[i].e_addr));
      chk($sformatf("vec%0d_din", i),  32'(din),  32'(vt[i].e_din));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
    end

    // random traffic with occasional aborts; model compares every cycle
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(3) != 0, 8'($urandom), $urandom_range(59) == 0);
    end
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // full frame of back-to-back bytes: four writes, frame_done on the last, then idle
    k = 0;
    for (int i = 0; i < 16; i++) begin
      drive(i < 12, seq[i], 1'b0);
      if (we) begin
        if (k < 4) begin
          chk($sformatf("frame_cycle%0d", k), 32'(i), 32'(3 * k + 4));
          chk($sformatf("frame_addr%0d", k),  32'(addr), 32'(k));
          chk($sformatf("frame_din%0d", k),   32'(din), 32'(px[k]));
          chk($sformatf("frame_done%0d", k),  32'(frame_done), 32'(k == 3));
        end
        k++;
      end
    end
    chk("frame_writes",    32'(k),    32'd4);
    chk("frame_end_busy",  32'(busy), 32'd0);
    chk("frame_end_addr",  32'(addr), 32'd0);

`ifdef PSW_BYTE_TIMEOUT_EN
    // two bytes, long silence, then a clean pixel
    chk_en = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    n_se = 0; n_wr = 0;
    drive(1'b1, 8'h55, 1'b0); n_se += int'(sync_err);
    drive(1'b1, 8'h66, 1'b0); n_se += int'(sync_err);
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      n_se += int'(sync_err);
      n_wr += int'(we);
    end
    chk("to_sync_err_pulses", 32'(n_se), 32'd1);
    chk("to_gap_writes",      32'(n_wr), 32'd0);
    chk("to_busy_after",      32'(busy), 32'd1);
    n_wr = 0; last_din = '0; last_addr = '1;
    drive(1'b1, 8'h0A, 1'b0);
    drive(1'b1, 8'h0B, 1'b0);
    drive(1'b1, 8'h0C, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      if (we) begin
        n_wr++;
        last_din  = din;
        last_addr = addr;
      end
    end
    chk("to_writes", 32'(n_wr),      32'd1);
    chk("to_din",    32'(last_din),  32'h0A0B0C);
    chk("to_addr",   32'(last_addr), 32'd0);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
